// File: rtl/event_recorder.sv
`default_nettype none
// ============================================================================
// event_recorder : timestamps changes on a monitored bus into a FWFT event FIFO
// Revision 1.0
// ============================================================================
module event_recorder #(
  parameter int WIDTH = 4,
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [WIDTH-1:0]           sig_in,
  input  logic                       clr_ovf,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [TS_W-1:0]            evt_time,
  output logic [WIDTH-1:0]           evt_value,
  output logic [WIDTH-1:0]           evt_mask,
  output logic                       evt_wrap,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = TS_W + 2 * WIDTH + 1;
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             base_q, base_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [EW-1:0]    mem_q [DEPTH];

  logic             not_empty;
  logic             pop;
  logic             rollover;
  logic             push_req;
  logic             wr;
  logic             drop;
  logic [WIDTH-1:0] mask;
  logic [EW-1:0]    wdata;
  logic [EW-1:0]    head;

  always_comb begin
    not_empty = (count_q != '0);
    pop       = not_empty & evt_ready;
    rollover  = en & (ts_q == '1);
    push_req  = en & (base_q | (sig_in != prev_q));
    mask      = base_q ? '1 : (sig_in ^ prev_q);
    // When full, a same-edge pop frees the slot the write lands in.
    wr        = push_req & ((count_q != c_full) | pop);
    drop      = push_req & ~wr;
    wdata     = {wrap_q | rollover, ts_q, sig_in, mask};

    ts_d      = en ? ts_q + 1'b1 : ts_q;
    prev_d    = en ? sig_in : prev_q;
    base_d    = ~en;
    wrap_d    = wr ? 1'b0 : (wrap_q | rollover);
    ovf_d     = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    wptr_d    = wr ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = pop ? rptr_q + 1'b1 : rptr_q;
    count_d   = count_q + CW'(wr) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q    <= '0;
      prev_q  <= '0;
      base_q  <= 1'b1;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      ts_q    <= ts_d;
      prev_q  <= prev_d;
      base_q  <= base_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  // Head is forced to zero when empty so stale storage never leaks out.
  always_comb begin
    head      = mem_q[rptr_q];
    evt_valid = not_empty;
    {evt_wrap, evt_time, evt_value, evt_mask} = not_empty ? head : '0;
    count     = count_q;
    overflow  = ovf_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_event_recorder.sv
`default_nettype none
// ============================================================================
// tb_event_recorder : table vectors, directed corner sequences and a random
// run against a queue-level reference model (TS_W=16 and TS_W=4 instances)
// Revision 1.0
// ============================================================================
module tb_event_recorder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] sig_in = '0;
  logic       clr_ovf = 1'b0;
  logic       evt_ready = 1'b0;

  logic        d0_valid, d0_wrap, d0_ovf;
  logic [15:0] d0_time;
  logic [3:0]  d0_value, d0_mask, d0_count;
  logic        d1_valid, d1_wrap, d1_ovf;
  logic [3:0]  d1_time;
  logic [3:0]  d1_value, d1_mask, d1_count;

  always #5 clk = ~clk;

  event_recorder #(.WIDTH(4), .TS_W(16), .DEPTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .clr_ovf(clr_ovf),
    .evt_valid(d0_valid), .evt_ready(evt_ready), .evt_time(d0_time),
    .evt_value(d0_value), .evt_mask(d0_mask), .evt_wrap(d0_wrap),
    .count(d0_count), .overflow(d0_ovf)
  );

  event_recorder #(.WIDTH(4), .TS_W(4), .DEPTH(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .clr_ovf(clr_ovf),
    .evt_valid(d1_valid), .evt_ready(evt_ready), .evt_time(d1_time),
    .evt_value(d1_value), .evt_mask(d1_mask), .evt_wrap(d1_wrap),
    .count(d1_count), .overflow(d1_ovf)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: list of pending entries per instance ----
  typedef struct packed {
    logic        w;
    logic [15:0] t;
    logic [3:0]  v;
    logic [3:0]  k;
  } ent_t;

  ent_t       mq [2][8];
  int         mn [2];
  int         mts [2];
  logic [3:0] mprev [2];
  bit         mbase [2];
  bit         mwrap [2];
  bit         movf [2];

  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      mn[m] = 0; mts[m] = 0; mprev[m] = '0;
      mbase[m] = 1'b1; mwrap[m] = 1'b0; movf[m] = 1'b0;
    end
  endtask

  task automatic mstep(int m, int tsw);
    int   modv;
    bit   do_pop, want, roll, pushed;
    ent_t e;
    modv   = 1 << tsw;
    do_pop = (mn[m] > 0) && (evt_ready == 1'b1);
    want   = (en == 1'b1) && (mbase[m] || (sig_in != mprev[m]));
    roll   = (en == 1'b1) && (mts[m] == modv - 1);
    e.w = mwrap[m] || roll;
    e.t = 16'(mts[m]);
    e.v = sig_in;
    e.k = mbase[m] ? 4'hF : (sig_in ^ mprev[m]);
    if (do_pop) begin
      for (int i = 0; i < 7; i++) mq[m][i] = mq[m][i+1];
      mn[m]--;
    end
    pushed = want && (mn[m] < 8);
    if (pushed) begin
      mq[m][mn[m]] = e;
      mn[m]++;
      mwrap[m] = 1'b0;
    end else begin
      mwrap[m] = mwrap[m] || roll;
    end
    if (want && !pushed) movf[m] = 1'b1;
    else if (clr_ovf) movf[m] = 1'b0;
    if (en) begin
      mprev[m] = sig_in;
      mts[m] = (mts[m] + 1) % modv;
    end
    mbase[m] = !en;
  endtask

  task automatic cmp(int m, logic v, logic [3:0] cnt, logic [15:0] t,
                     logic [3:0] val, logic [3:0] msk, logic w, logic o);
    ent_t h;
    logic ev;
    h  = '0;
    ev = (mn[m] > 0);
    if (ev) h = mq[m][0];
    chk($sformatf("m%0d valid", m), 64'(v), 64'(ev));
    chk($sformatf("m%0d count", m), 64'(cnt), 64'(mn[m]));
    chk($sformatf("m%0d time", m), 64'(t), 64'(h.t));
    chk($sformatf("m%0d value", m), 64'(val), 64'(h.v));
    chk($sformatf("m%0d mask", m), 64'(msk), 64'(h.k));
    chk($sformatf("m%0d wrap", m), 64'(w), 64'(h.w));
    chk($sformatf("m%0d overflow", m), 64'(o), 64'(movf[m]));
  endtask

  task automatic edge_step();
    @(posedge clk);
    mstep(0, 16);
    mstep(1, 4);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mreset();
    en = 1'b0; sig_in = '0; evt_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic head0(string tag, int cnt, int t, logic [3:0] val, logic [3:0] msk);
    chk({tag, " count"}, 64'(d0_count), 64'(cnt));
    chk({tag, " time"}, 64'(d0_time), 64'(t));
    chk({tag, " value"}, 64'(d0_value), 64'(val));
    chk({tag, " mask"}, 64'(d0_mask), 64'(msk));
  endtask

  // ---------------- table vectors: baseline, two changes, empty push+ready ----
  typedef struct {
    logic       en;
    logic [3:0] sig;
    logic       rdy;
    logic       clr;
    logic       v;
    int         cnt;
    int         t;
    logic [3:0] val;
    logic [3:0] msk;
    logic       ovf;
  } vec_t;

  function automatic vec_t mk(logic e, logic [3:0] s, logic r, logic c, logic v,
                              int cnt, int t, logic [3:0] val, logic [3:0] msk, logic o);
    vec_t x;
    x.en = e; x.sig = s; x.rdy = r; x.clr = c; x.v = v;
    x.cnt = cnt; x.t = t; x.val = val; x.msk = msk; x.ovf = o;
    return x;
  endfunction

  vec_t tbl [15];

  initial begin
    tbl[0]  = mk(1, 4'h0, 0, 0, 1, 1, 0, 4'h0, 4'hF, 0);
    tbl[1]  = mk(1, 4'h0, 0, 0, 1, 1, 0, 4'h0, 4'hF, 0);
    tbl[2]  = mk(1, 4'h0, 0, 0, 1, 1, 0, 4'h0, 4'hF, 0);
    tbl[3]  = mk(1, 4'h0, 0, 0, 1, 1, 0, 4'h0, 4'hF, 0);
    tbl[4]  = mk(1, 4'h0, 0, 0, 1, 1, 0, 4'h0, 4'hF, 0);
    tbl[5]  = mk(1, 4'hD, 0, 0, 1, 2, 0, 4'h0, 4'hF, 0);
    tbl[6]  = mk(1, 4'hD, 1, 0, 1, 1, 5, 4'hD, 4'hD, 0);
    tbl[7]  = mk(1, 4'hD, 0, 0, 1, 1, 5, 4'hD, 4'hD, 0);
    tbl[8]  = mk(1, 4'hD, 0, 0, 1, 1, 5, 4'hD, 4'hD, 0);
    tbl[9]  = mk(1, 4'hC, 0, 0, 1, 2, 5, 4'hD, 4'hD, 0);
    tbl[10] = mk(1, 4'hC, 1, 0, 1, 1, 9, 4'hC, 4'h1, 0);
    tbl[11] = mk(1, 4'hC, 1, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    tbl[12] = mk(1, 4'hC, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0);
    tbl[13] = mk(1, 4'h0, 1, 0, 1, 1, 13, 4'h0, 4'hC, 0);
    tbl[14] = mk(1, 4'h0, 0, 0, 1, 1, 13, 4'h0, 4'hC, 0);

    // reset state
    do_reset();
    #1;
    chk("reset valid", 64'(d0_valid), 64'(0));
    chk("reset count", 64'(d0_count), 64'(0));
    chk("reset overflow", 64'(d0_ovf), 64'(0));
    chk("reset time", 64'(d0_time), 64'(0));
    chk("reset4 valid", 64'(d1_valid), 64'(0));

    for (int i = 0; i < 15; i++) begin
      en = tbl[i].en; sig_in = tbl[i].sig; evt_ready = tbl[i].rdy; clr_ovf = tbl[i].clr;
      edge_step();
      chk($sformatf("vec%0d valid", i), 64'(d0_valid), 64'(tbl[i].v));
      head0($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].t, tbl[i].val, tbl[i].msk);
      chk($sformatf("vec%0d wrap", i), 64'(d0_wrap), 64'(0));
      chk($sformatf("vec%0d overflow", i), 64'(d0_ovf), 64'(tbl[i].ovf));
    end

    // overflow, clear priority, full with simultaneous pop+push
    do_reset();
    en = 1'b1; evt_ready = 1'b0; clr_ovf = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      sig_in = {3'b000, k[0]};
      edge_step();
      if (k == 7) begin
        chk("fill8 count", 64'(d0_count), 64'(8));
        chk("fill8 overflow", 64'(d0_ovf), 64'(0));
      end
    end
    chk("drop9 count", 64'(d0_count), 64'(8));
    chk("drop9 overflow", 64'(d0_ovf), 64'(1));
    sig_in = 4'h1; clr_ovf = 1'b1;
    edge_step();
    chk("clr+drop overflow", 64'(d0_ovf), 64'(1));
    edge_step();
    chk("clr alone overflow", 64'(d0_ovf), 64'(0));
    head0("full stable head", 8, 0, 4'h0, 4'hF);
    clr_ovf = 1'b0; sig_in = 4'h0; evt_ready = 1'b1;
    edge_step();
    head0("full pop+push", 8, 1, 4'h1, 4'h1);
    chk("full pop+push overflow", 64'(d0_ovf), 64'(0));
    evt_ready = 1'b0;

    // timestamp rollover on the TS_W=4 instance
    do_reset();
    en = 1'b1; sig_in = 4'h0; evt_ready = 1'b0;
    edge_step();
    evt_ready = 1'b1;
    edge_step();
    evt_ready = 1'b0;
    repeat (21) edge_step();
    sig_in = 4'h1;
    edge_step();
    chk("wrap4 count", 64'(d1_count), 64'(1));
    chk("wrap4 wrap", 64'(d1_wrap), 64'(1));
    chk("wrap4 time", 64'(d1_time), 64'(7));
    chk("wrap16 wrap", 64'(d0_wrap), 64'(0));
    chk("wrap16 time", 64'(d0_time), 64'(23));
    evt_ready = 1'b1;
    edge_step();
    evt_ready = 1'b0;
    edge_step();
    sig_in = 4'h0;
    edge_step();
    chk("nowrap4 count", 64'(d1_count), 64'(1));
    chk("nowrap4 wrap", 64'(d1_wrap), 64'(0));
    chk("nowrap4 time", 64'(d1_time), 64'(10));
    chk("nowrap4 mask", 64'(d1_mask), 64'(1));

    // asynchronous reset with entries queued
    do_reset();
    en = 1'b1; evt_ready = 1'b0;
    sig_in = 4'h0; edge_step();
    sig_in = 4'h1; edge_step();
    sig_in = 4'h2; edge_step();
    chk("pre-reset count", 64'(d0_count), 64'(3));
    #2;
    rst_n = 1'b0;
    mreset();
    #1;
    chk("async reset valid", 64'(d0_valid), 64'(0));
    chk("async reset count", 64'(d0_count), 64'(0));
    chk("async reset4 count", 64'(d1_count), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    sig_in = 4'h6;
    edge_step();
    head0("post-reset baseline", 1, 0, 4'h6, 4'hF);

    // randomized run against the reference model
    do_reset();
    #1;
    cmp(0, d0_valid, d0_count, d0_time, d0_value, d0_mask, d0_wrap, d0_ovf);
    cmp(1, d1_valid, d1_count, {12'h000, d1_time}, d1_value, d1_mask, d1_wrap, d1_ovf);
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0) sig_in = 4'($urandom);
      if (((c / 300) % 2) == 0) evt_ready = ($urandom_range(0, 3) == 0);
      else evt_ready = ($urandom_range(0, 3) != 0);
      clr_ovf = ($urandom_range(0, 15) == 0);
      edge_step();
      cmp(0, d0_valid, d0_count, d0_time, d0_value, d0_mask, d0_wrap, d0_ovf);
      cmp(1, d1_valid, d1_count, {12'h000, d1_time}, d1_value, d1_mask, d1_wrap, d1_ovf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
